// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round helper functions.
package sha256_pkg;

  // [7] = a / H0 ... [0] = h / H7, so a packed hstate_t is the digest layout
  typedef logic [7:0][31:0]  hstate_t;
  // [15] holds the oldest word (W_t of the next round), [0] the newest
  typedef logic [15:0][31:0] win_t;

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} state_t;

  localparam hstate_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam hstate_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // W[t+16] from the window holding W[t..t+15]
  function automatic logic [31:0] sched_next(input win_t w);
    return ssig1(w[1]) + w[6] + ssig0(w[14]) + w[15];
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  hstate_t     cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output hstate_t     nxt
);

  logic [31:0] t1, t2;

  assign t1  = cur[0] + bsig1(cur[3]) + ch(cur[3], cur[2], cur[1]) + k + w;
  assign t2  = bsig0(cur[7]) + maj(cur[7], cur[6], cur[5]);
  assign nxt = {t1 + t2, cur[7], cur[6], cur[5], cur[4] + t1, cur[3], cur[2], cur[1]};

endmodule

// File: rtl/sha256_multiblock.sv
// Multi-block SHA-256 core, ROUNDS_PER_CYCLE rounds per clock.
// Optional SHA-224 mode (mode_224 port) when SHA256_SHA224_EN is defined.
module sha256_multiblock
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
`ifdef SHA256_SHA224_EN
  ,
  input  logic         mode_224
`endif
);

  localparam int NCYC = 64 / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("sha256_multiblock: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t     state;
  hstate_t    h, wv, iv_sel;
  win_t       win;
  logic [5:0] cnt;
  logic       last_q, chain_ok, fresh;

  // chain_ok is set only between blocks of an unfinished message
  assign fresh = blk_first || !chain_ok;
  assign busy  = (state != IDLE);

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
    hstate_t    cur, nxt;
    win_t       wcur, wnxt;
    logic [5:0] kidx;
    if (j == 0) begin : g_head
      assign cur  = wv;
      assign wcur = win;
    end else begin : g_link
      assign cur  = g_rnd[j-1].nxt;
      assign wcur = g_rnd[j-1].wnxt;
    end
    assign kidx = cnt * 6'(ROUNDS_PER_CYCLE) + 6'(j);
    assign wnxt = {wcur[14:0], sched_next(wcur)};
    sha256_round u_round (.cur(cur), .k(K[kidx]), .w(wcur[15]), .nxt(nxt));
  end

`ifdef SHA256_SHA224_EN
  logic m224;
  assign iv_sel = mode_224 ? IV224 : IV256;
  assign digest = m224 ? {h[7:1], 32'h0} : h;
`else
  assign iv_sel = IV256;
  assign digest = h;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk_ready <= 1'b0;
      dig_valid <= 1'b0;
      h         <= '0;
      wv        <= '0;
      win       <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      chain_ok  <= 1'b0;
`ifdef SHA256_SHA224_EN
      m224      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          blk_ready <= 1'b1;
          if (blk_valid && blk_ready) begin
            blk_ready <= 1'b0;
            state     <= ROUND;
            cnt       <= '0;
            wv        <= fresh ? iv_sel : h;
            win       <= blk_data;
            last_q    <= blk_last;
            if (fresh) h <= iv_sel;
`ifdef SHA256_SHA224_EN
            if (fresh) m224 <= mode_224;
`endif
          end
        end
        ROUND: begin
          wv  <= g_rnd[ROUNDS_PER_CYCLE-1].nxt;
          win <= g_rnd[ROUNDS_PER_CYCLE-1].wnxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(NCYC - 1)) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + wv[i];
          chain_ok <= !last_q;
          state    <= last_q ? OUT : IDLE;
        end
        OUT: begin
          // dig_valid trails entry to OUT by one edge so it lands at NCYC+2
          if (!dig_valid) begin
            dig_valid <= 1'b1;
          end else if (dig_ready) begin
            dig_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Directed bench for sha256_multiblock with known-answer digests.
module tb_sha256_multiblock;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid, blk_first, blk_last, dig_ready;
  logic [511:0] blk_data;
  logic         blk_ready, dig_valid, busy;
  logic [255:0] digest;
  logic         v4, dr4, rdy4, dv4, busy4;
  logic [255:0] dig4;
`ifdef SHA256_SHA224_EN
  logic         mode_224;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] TB1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TB2   = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  always #5 clk = ~clk;

  sha256_multiblock #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest), .busy(busy)
`ifdef SHA256_SHA224_EN
    , .mode_224(mode_224)
`endif
  );

  sha256_multiblock #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .blk_valid(v4), .blk_ready(rdy4),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dv4), .dig_ready(dr4), .digest(dig4), .busy(busy4)
`ifdef SHA256_SHA224_EN
    , .mode_224(1'b0)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns #1 after the accepting edge
  task automatic send(input logic [511:0] d, input logic f, input logic l);
    int n = 0;
    while (!blk_ready && n < 300) begin step(); n++; end
    check("ready_wait", n < 300, 1);
    blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
  endtask

  task automatic wait_dig(output int n);
    n = 0;
    do begin step(); n++; end while (!dig_valid && n < 300);
  endtask

  task automatic take();
    dig_ready = 1'b1;
    step();
    dig_ready = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    blk_data = '0; dig_ready = 1'b0; v4 = 1'b0; dr4 = 1'b0;
`ifdef SHA256_SHA224_EN
    mode_224 = 1'b0;
`endif
    repeat (3) step();
    check("rst_blk_ready", blk_ready, 0);
    check("rst_dig_valid", dig_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digest", digest, 0);
    rst_n = 1'b1;
    step();
    check("rel_blk_ready", blk_ready, 1);

    // "abc" with consumer stalled for 10 cycles
    send(ABC, 1, 1);
    check("acc_busy", busy, 1);
    check("acc_blk_ready", blk_ready, 0);
    wait_dig(n);
    check("abc_latency", n, 66);
    check("abc_digest", digest, D_ABC);
    repeat (10) begin
      step();
      check("stall_digest", digest, D_ABC);
      check("stall_blk_ready", blk_ready, 0);
      check("stall_dig_valid", dig_valid, 1);
    end
    take();
    check("take_dig_valid", dig_valid, 0);

    send(EMPTY, 1, 1);
    wait_dig(n);
    check("empty_digest", digest, D_EMP);
    take();

    // two-block message
    send(TB1, 1, 0);
    n = 0;
    do begin step(); n++; end while (!blk_ready && n < 300);
    check("two_ready_lat", n, 66);
    check("two_no_dig", dig_valid, 0);
    send(TB2, 0, 1);
    wait_dig(n);
    check("two_digest", digest, D_TWO);
    take();

    // first=0 after a completed message still starts from IV
    send(ABC, 0, 1);
    wait_dig(n);
    check("fresh_iv_digest", digest, D_ABC);
    take();

    // first=1 mid-message discards the chain
    send(TB1, 1, 0);
    send(ABC, 1, 1);
    wait_dig(n);
    check("restart_digest", digest, D_ABC);
    take();

    // four rounds per cycle
    n = 0;
    while (!rdy4 && n < 300) begin step(); n++; end
    blk_data = ABC; blk_first = 1'b1; blk_last = 1'b1; v4 = 1'b1;
    step();
    v4 = 1'b0;
    check("r4_busy", busy4, 1);
    n = 0;
    do begin step(); n++; end while (!dv4 && n < 300);
    check("r4_latency", n, 18);
    check("r4_digest", dig4, D_ABC);
    dr4 = 1'b1; step(); dr4 = 1'b0;
    check("r4_taken", dv4, 0);

    // reset during ROUND aborts the message
    send(ABC, 1, 1);
    repeat (30) step();
    rst_n = 1'b0;
    step();
    check("abort_dig_valid", dig_valid, 0);
    check("abort_digest", digest, 0);
    check("abort_busy", busy, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin step(); if (dig_valid) seen = 1'b1; end
    check("abort_no_digest", seen, 0);
    send(ABC, 1, 1);
    wait_dig(n);
    check("after_abort_lat", n, 66);
    check("after_abort_digest", digest, D_ABC);
    take();

`ifdef SHA256_SHA224_EN
    mode_224 = 1'b1;
    send(ABC, 1, 1);
    mode_224 = 1'b0;
    wait_dig(n);
    check("sha224_digest", digest,
          {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0});
    take();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
